// File: rtl/ifid_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ifid_fetch_queue
//  Purpose  : IF/ID decoupling queue with registered ID-side output, bypass
//             on empty, and single-edge flush on taken redirects.
//  Revision : 1.0  initial release
// ============================================================================
module ifid_fetch_queue #(
  parameter int                PC_W  = 30,
  parameter int                INS_W = 32,
  parameter int                DEPTH = 4,
  parameter logic [INS_W-1:0]  NOP   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_valid,
  input  logic [PC_W-1:0]              if_pc_plus_4,
  input  logic [INS_W-1:0]             if_ins,
  output logic                         if_ready,
  input  logic                         id_stall,
  input  logic                         flush,
  output logic                         id_valid,
  output logic [PC_W-1:0]              id_pc_plus_4,
  output logic [INS_W-1:0]             id_ins,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int                c_PW    = $clog2(DEPTH);
  localparam int                c_CW    = $clog2(DEPTH+1);
  localparam logic [c_CW-1:0]   c_DEPTH = c_CW'(DEPTH);

  logic [PC_W-1:0]   r_mem_pc  [DEPTH];
  logic [INS_W-1:0]  r_mem_ins [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic              r_id_valid;
  logic [PC_W-1:0]   r_id_pc;
  logic [INS_W-1:0]  r_id_ins;

  logic              w_push_ok;
  logic              w_wr_en;
  logic              w_has_entry;

  assign w_has_entry = (r_count != '0);
  assign w_push_ok   = if_valid && if_ready && !flush;
  // The bypass path (empty queue, ID advancing) never touches storage.
  assign w_wr_en     = w_push_ok && (id_stall || w_has_entry);

  assign if_ready     = (r_count < c_DEPTH);
  assign full         = (r_count == c_DEPTH);
  assign empty        = !w_has_entry;
  assign count        = r_count;
  assign id_valid     = r_id_valid;
  assign id_pc_plus_4 = r_id_pc;
  assign id_ins       = r_id_ins;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_pc[r_wr_ptr]  <= if_pc_plus_4;
      r_mem_ins[r_wr_ptr] <= if_ins;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_id_valid <= 1'b0;
      r_id_ins   <= NOP;
      r_id_pc    <= '0;
    end else if (flush) begin
      // Redirect target PC+4 rides along with the bubble presented to ID.
      r_count    <= '0;
      r_rd_ptr   <= r_wr_ptr;
      r_id_valid <= 1'b0;
      r_id_ins   <= NOP;
      r_id_pc    <= if_pc_plus_4;
    end else if (id_stall) begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end
    end else if (w_has_entry) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_mem_pc[r_rd_ptr];
      r_id_ins   <= r_mem_ins[r_rd_ptr];
      r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end else begin
        r_count  <= r_count - 1'b1;
      end
    end else if (if_valid) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= if_pc_plus_4;
      r_id_ins   <= if_ins;
    end else begin
      r_id_valid <= 1'b0;
      r_id_ins   <= NOP;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifid_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifid_fetch_queue
//  Purpose  : Self-checking bench for ifid_fetch_queue using a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifid_fetch_queue;

  localparam int c_DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         if_valid;
  logic [29:0]  if_pc_plus_4;
  logic [31:0]  if_ins;
  logic         if_ready;
  logic         id_stall;
  logic         flush;
  logic         id_valid;
  logic [29:0]  id_pc_plus_4;
  logic [31:0]  id_ins;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  ifid_fetch_queue #(
    .PC_W  (30),
    .INS_W (32),
    .DEPTH (c_DEPTH),
    .NOP   (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_pc_plus_4 (if_pc_plus_4),
    .if_ins       (if_ins),
    .if_ready     (if_ready),
    .id_stall     (id_stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_pc_plus_4 (id_pc_plus_4),
    .id_ins       (id_ins),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Model state: queue of {pc_plus_4, ins} plus the ID register.
  logic [61:0] m_q[$];
  logic [61:0] src[$];
  logic        m_v   = 1'b0;
  logic [31:0] m_ins = '0;
  logic [29:0] m_pc  = '0;
  logic        m_acc = 1'b0;
  int          m_deliv = 0;
  logic [31:0] m_last = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [61:0] mk(input logic [31:0] ins);
    return {30'h40 + 30'(ins[15:0]), ins};
  endfunction

  task automatic model_update();
    logic        rdy;
    logic        push;
    logic [61:0] h;
    rdy   = (m_q.size() < c_DEPTH);
    push  = if_valid && rdy && !flush;
    m_acc = push && rst_n;
    if (!rst_n) begin
      m_q.delete(); m_v = 1'b0; m_ins = '0; m_pc = '0;
    end else if (flush) begin
      m_q.delete(); m_v = 1'b0; m_ins = '0; m_pc = if_pc_plus_4;
    end else if (id_stall) begin
      if (push) m_q.push_back({if_pc_plus_4, if_ins});
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      m_v = 1'b1; m_pc = h[61:32]; m_ins = h[31:0];
      m_deliv++; m_last = m_ins;
      if (push) m_q.push_back({if_pc_plus_4, if_ins});
    end else if (if_valid) begin
      m_v = 1'b1; m_pc = if_pc_plus_4; m_ins = if_ins;
      m_deliv++; m_last = m_ins;
    end else begin
      m_v = 1'b0; m_ins = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic drive(input logic v, input logic [61:0] e, input logic st, input logic fl);
    rst_n = 1'b1; if_valid = v; if_pc_plus_4 = e[61:32]; if_ins = e[31:0];
    id_stall = st; flush = fl;
    step();
  endtask

  // Present the oldest pending source instruction and hold it until accepted.
  task automatic feed(input logic st);
    if (src.size() > 0) drive(1'b1, src[0], st, 1'b0);
    else                drive(1'b0, 62'h0, st, 1'b0);
    if (m_acc) void'(src.pop_front());
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("id_valid", 64'(id_valid), 64'(m_v));
      check("id_ins", 64'(id_ins), 64'(m_ins));
      check("id_pc", 64'(id_pc_plus_4), 64'(m_pc));
      check("count", 64'(count), 64'(m_q.size()));
      check("full", 64'(full), 64'(m_q.size() == c_DEPTH));
      check("empty", 64'(empty), 64'(m_q.size() == 0));
      check("if_ready", 64'(if_ready), 64'(m_q.size() < c_DEPTH));
    end
  end

  initial begin
    int k;
    int d0;
    rst_n = 1'b0; if_valid = 1'b1; if_pc_plus_4 = 30'h55; if_ins = 32'h77;
    id_stall = 1'b0; flush = 1'b0;
    repeat (2) begin
      step();
      chk_en = 1'b1;
    end
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_ins", 64'(id_ins), 64'd0);
    check("rst_pc", 64'(id_pc_plus_4), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(if_ready), 64'd1);

    // Bypass stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(32'hA1 + 32'(i)), 1'b0, 1'b0);
      check("byp_ins", 64'(id_ins), 64'(32'hA1 + 32'(i)));
      check("byp_count", 64'(count), 64'd0);
    end
    drive(1'b0, 62'h0, 1'b0, 1'b0);
    check("byp_idle", 64'(id_valid), 64'd0);

    // Stall fill beyond DEPTH
    for (int i = 0; i < 6; i++) src.push_back(mk(32'hB0 + 32'(i)));
    repeat (6) feed(1'b1);
    check("fill_count", 64'(count), 64'd4);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(if_ready), 64'd0);
    check("fill_held", 64'(src.size()), 64'd2);
    feed(1'b0);
    check("fill_first", 64'(id_ins), 64'hB0);
    k = 0;
    while ((src.size() > 0 || m_q.size() > 0) && k < 20) begin
      feed(1'b0);
      k++;
    end
    check("fill_drained", 64'(m_q.size() + src.size()), 64'd0);
    check("fill_last", 64'(m_last), 64'hB5);
    drive(1'b0, 62'h0, 1'b0, 1'b0);

    // Simultaneous push/pop at count=2
    src.push_back(mk(32'hC0));
    src.push_back(mk(32'hC1));
    repeat (2) feed(1'b1);
    check("pp_pre", 64'(count), 64'd2);
    for (int i = 2; i < 8; i++) src.push_back(mk(32'hC0 + 32'(i)));
    repeat (6) begin
      feed(1'b0);
      check("pp_count", 64'(count), 64'd2);
    end
    check("pp_head", 64'(id_ins), 64'hC5);

    // Flush while stalled
    src.push_back(mk(32'hC8));
    feed(1'b1);
    check("fl_pre", 64'(count), 64'd3);
    drive(1'b1, {30'h100, 32'hDEAD}, 1'b1, 1'b1);
    check("fl_valid", 64'(id_valid), 64'd0);
    check("fl_ins", 64'(id_ins), 64'd0);
    check("fl_pc", 64'(id_pc_plus_4), 64'h100);
    check("fl_count", 64'(count), 64'd0);
    check("fl_ready", 64'(if_ready), 64'd1);
    repeat (3) drive(1'b0, 62'h0, 1'b0, 1'b0);
    check("fl_after", 64'(id_valid), 64'd0);
    check("fl_pc_hold", 64'(id_pc_plus_4), 64'h100);

    // Pointer wrap with alternating 2-cycle stalls
    for (int i = 0; i < 3 * c_DEPTH; i++) src.push_back(mk(32'hE0 + 32'(i)));
    d0 = m_deliv;
    k = 0;
    while ((src.size() > 0 || m_q.size() > 0) && k < 100) begin
      feed((k % 4) < 2);
      k++;
    end
    check("wrap_done", 64'(src.size() + m_q.size()), 64'd0);
    check("wrap_deliv", 64'(m_deliv - d0), 64'd12);
    check("wrap_last", 64'(m_last), 64'hEB);

    // Reset mid-operation beats flush, stall and if_valid
    for (int i = 0; i < 3; i++) src.push_back(mk(32'hF0 + 32'(i)));
    repeat (3) feed(1'b1);
    check("mr_pre", 64'(count), 64'd3);
    rst_n = 1'b0; if_valid = 1'b1; if_pc_plus_4 = 30'h222; if_ins = 32'h99;
    id_stall = 1'b1; flush = 1'b1;
    step();
    check("mr_count", 64'(count), 64'd0);
    check("mr_valid", 64'(id_valid), 64'd0);
    check("mr_pc", 64'(id_pc_plus_4), 64'd0);
    check("mr_ready", 64'(if_ready), 64'd1);
    drive(1'b0, 62'h0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifid_fetch_queue.md
# ifid_fetch_queue

Parametrised IF/ID decoupling stage between instruction fetch and decode. It replaces the single-entry IF/ID register with a DEPTH-entry in-order instruction queue feeding a registered ID-side output. Fetch can run ahead while decode is stalled by a hazard or branch bubble. A taken redirect flushes every queued instruction and presents a NOP to decode.

## Interface
Parameters:
- PC_W, 30, width of the word-address PC+4 field.
- INS_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, 2..16.
- NOP, 0 (INS_W bits), instruction value presented to ID on flush, empty or reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- if_valid  in  1  IF presents an instruction this cycle.
- if_pc_plus_4  in  PC_W  PC+4 of the IF instruction.
- if_ins  in  INS_W  fetched instruction.
- if_ready  out  1  queue can accept; equals (count < DEPTH); depends on registered state only.
- id_stall  in  1  hold ID register (load-use hazard or branch bubble).
- flush  in  1  taken branch/jump/jal/jalr redirect resolved this cycle.
- id_valid  out  1  id_ins is a real instruction.
- id_pc_plus_4  out  PC_W  PC+4 of the ID instruction.
- id_ins  out  INS_W  instruction to decode.
- count  out  $clog2(DEPTH+1)  entries currently queued, excluding the ID register.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH-entry circular buffer of {pc_plus_4, ins}, with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits; both wrap modulo DEPTH.
- push_ok = if_valid && if_ready && !flush.
- Priority per clock edge: reset > flush > stall > advance.
- Reset (rst_n=0 at edge):
  - count=0, wr_ptr=rd_ptr=0.
  - id_valid=0, id_ins=NOP, id_pc_plus_4=0.
  - Queue contents are don't-care.
- Flush (flush=1):
  - count←0, rd_ptr←wr_ptr.
  - id_valid←0, id_ins←NOP, id_pc_plus_4←if_pc_plus_4.
  - The IF input that cycle is discarded.
  - Flush overrides id_stall.
- Stall (flush=0, id_stall=1):
  - id_* hold.
  - If push_ok, the IF entry is written at wr_ptr, wr_ptr++, count++.
- Advance (flush=0, id_stall=0):
  - count>0: id_* ← head entry, id_valid←1, rd_ptr++. A simultaneous push_ok writes at wr_ptr, so count is unchanged; otherwise count--.
  - count==0 and if_valid: bypass. id_* ← IF inputs, id_valid←1; nothing is written to the queue.
  - count==0 and !if_valid: id_valid←0, id_ins←NOP, id_pc_plus_4 holds.
- Ordering: strictly program order. No entry is ever duplicated or dropped, except by flush.
- When full, if_ready=0. IF must hold if_valid and its data until accepted; the block does not check this.

## Timing
- Latency IF→ID: 1 cycle when the queue is empty and ID is not stalled (bypass). Otherwise 1 cycle after the entry reaches the head and ID advances.
- Throughput: 1 instruction/cycle sustained.
- if_ready, full, empty and count are registered-state functions, with no combinational path from id_stall or flush. A slot freed by a pop becomes visible the next cycle.
- Flush takes effect at the same edge. The next cycle shows id_valid=0, count=0 and if_ready=1.
- Reset asserted mid-operation discards all entries at that edge, regardless of flush, stall or if_valid.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with if_valid=1 -> id_valid=0, id_ins=0, id_pc_plus_4=0, count=0, if_ready=1.
- Bypass stream: no stall, push ins 0xA1..0xA4 on consecutive cycles -> id_ins=0xA1..0xA4 one cycle later each; count stays 0.
- Stall fill: id_stall=1 for 6 cycles while pushing 0xB0..0xB5 (DEPTH=4) -> count reaches 4, full=1 and if_ready=0 after 4 accepts. On release, id_ins is 0xB0,0xB1,... in order, and the held 0xB4 and 0xB5 follow without loss.
- Simultaneous push/pop: count=2, no stall, push every cycle -> count stays 2 and order is preserved.
- Flush with stall: count=3, id_stall=1, flush=1, if_pc_plus_4=0x100 -> next cycle id_valid=0, id_ins=NOP, id_pc_plus_4=0x100, count=0. Old entries never appear on id_ins.
- Pointer wrap: 3×DEPTH pushes with alternating 2-cycle stalls -> all instructions appear in order at ID.
